game_flow_ctrl: RTL and testbench
=================================

// Module: game_flow_ctrl
// PURPOSE
//  Game-level sequencer for the shooter datapath: owns the start/countdown/play/win/lose
//  flow, gates the player/fire buttons toward playerHandle and bulletHandle, issues a
//  one-cycle soft reset to the enemy/bullet blocks on a new round, and keeps the score.
//  Replaces the asynchronous collision-clocked score counter with one synchronous
//  counter in the clk domain. The score feeds the seg driver.
// PARAMETERS
//  START_FRAMES  180  frame ticks spent in COUNTDOWN before PLAY (8-bit counter)
//  HOLD_FRAMES   60   frame ticks WIN/LOSE must last before a fire press returns to IDLE
//  SCORE_MAX     9    score saturation value (4-bit)
// PORTS
//  clk           in   1  game clock (frame/line-rate domain)
//  reset         in   1  async, active-low; clears all state
//  frame_tick    in   1  one-cycle pulse per video frame, clk domain
//  pbL_in        in   1  raw left button, active-low (1 = released)
//  pbR_in        in   1  raw right button, active-low
//  pbG_in        in   1  raw fire button, active-low
//  collision     in   1  bullet/enemy hit level, asynchronous to clk
//  endgame_win   in   1  all enemies destroyed (level)
//  endgame_lose  in   1  enemy reached player row (level)
//  pbL_out       out  1  gated left button to playerHandle; forced 1 when locked
//  pbR_out       out  1  gated right button; forced 1 when locked
//  pbG_out       out  1  gated fire button to bulletHandle; forced 1 when locked
//  round_rst_n   out  1  active-low soft reset to enemy/bullet/player, 1-cycle pulse
//  move_en       out  1  high only in PLAY; qualifies MOVE_CLK consumers
//  state         out  3  IDLE=0 COUNTDOWN=1 PLAY=2 WIN=3 LOSE=4 (PAUSE=5 if enabled)
//  score         out  4  hits this round, 0..SCORE_MAX
// BEHAVIOUR
//  - Reset values: state=IDLE, score=0, pb*_out=1, round_rst_n=1, move_en=0, counters=0.
//  - All buttons and collision pass through 2-FF synchronizers; a "press" is a 1->0 edge of
//    the synced button; a "hit" is a 0->1 edge of synced collision. Input pulses must be
//    >=3 clk wide. Output latency from a raw input to its gated output is 2 clk.
//  - Button gating: pb*_out = synced pb* in PLAY, else 1.
//  - IDLE: on pbG press -> COUNTDOWN. Load cnt=START_FRAMES, clear score to 0, and drive
//    round_rst_n=0 for exactly the first cycle in COUNTDOWN.
//  - COUNTDOWN: cnt decrements on frame_tick; the tick that takes cnt to 0 -> PLAY on the
//    next clk. START_FRAMES=0 -> PLAY on the first frame_tick.
//  - PLAY: move_en=1. On a hit, score+1, saturating at SCORE_MAX (further hits ignored).
//    endgame_lose -> LOSE; endgame_win -> WIN. If both are high in the same cycle, LOSE wins.
//    A hit in the same cycle as an endgame transition still counts.
//  - WIN/LOSE: buttons locked, score frozen, cnt counts frame_ticks up to HOLD_FRAMES and
//    saturates there. A pbG press with cnt==HOLD_FRAMES -> IDLE. Earlier presses are ignored.
//  - endgame_* while not in PLAY are ignored.
//  - Async reset mid-round returns to IDLE immediately. round_rst_n is not asserted by the
//    hard reset; downstream blocks take reset directly.
//  - Unused state encodings (6, 7) -> IDLE on the next clk.
// CONFIGURATION
//  GAME_PAUSE_EN defined:
//    - Adds input pbP_in (1 bit, active-low, synchronized like the other buttons).
//    - A pbP press in PLAY -> PAUSE (state=5): buttons locked, move_en=0, score frozen,
//      endgame_* ignored. A pbP press in PAUSE -> PLAY. Presses in any other state are ignored.
//  GAME_PAUSE_EN not defined:
//    - No pbP_in port and no PAUSE state; encoding 5 is treated as unused.
// TESTING
//  1 reset low, then high; press pbG; START_FRAMES=3 -> round_rst_n low 1 clk, state=1,
//    state=2 after the 3rd frame_tick, move_en=1.
//  2 PLAY, 12 collision pulses of 4 clk -> score steps 1..9 and holds at 9.
//  3 PLAY, endgame_win and endgame_lose rise in the same clk -> state=4, pb*_out=1 while
//    raw buttons are pressed.
//  4 LOSE, HOLD_FRAMES=2: pbG press after 1 tick -> stays 4; after 2 ticks -> state=0;
//    next pbG press -> score=0 and state=1.
//  5 PLAY with score=5, pulse reset low for 1 clk -> state=0, score=0, pb*_out=1, move_en=0.
//  6 (GAME_PAUSE_EN) PLAY, press pbP -> state=5, hits ignored; press pbP -> state=2,
//    score unchanged.

Source files
------------

// File: rtl/game_flow_ctrl.sv
// Game-level sequencer: round flow, button gating, round soft reset and score keeping.
// Optional PAUSE state and pbP_in button are compiled in when GAME_PAUSE_EN is defined.
module game_flow_ctrl #(
    parameter int START_FRAMES = 180,
    parameter int HOLD_FRAMES  = 60,
    parameter int SCORE_MAX    = 9
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       pbL_in,
    input  logic       pbR_in,
    input  logic       pbG_in,
`ifdef GAME_PAUSE_EN
    input  logic       pbP_in,
`endif
    input  logic       collision,
    input  logic       endgame_win,
    input  logic       endgame_lose,
    output logic       pbL_out,
    output logic       pbR_out,
    output logic       pbG_out,
    output logic       round_rst_n,
    output logic       move_en,
    output logic [2:0] state,
    output logic [3:0] score
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        COUNTDOWN = 3'd1,
        PLAY      = 3'd2,
        WIN       = 3'd3,
        LOSE      = 3'd4
`ifdef GAME_PAUSE_EN
        , PAUSE   = 3'd5
`endif
    } gameState_t;

    localparam logic [7:0] START_CNT = 8'(START_FRAMES);
    localparam logic [7:0] HOLD_CNT  = 8'(HOLD_FRAMES);
    localparam logic [3:0] SCORE_TOP = 4'(SCORE_MAX);

    // Sync bit order: L, R, G, collision (, P). Buttons idle high, collision idles low.
`ifdef GAME_PAUSE_EN
    localparam int NSYNC = 5;
    localparam logic [NSYNC-1:0] SYNC_INIT = 5'b10111;
`else
    localparam int NSYNC = 4;
    localparam logic [NSYNC-1:0] SYNC_INIT = 4'b0111;
`endif

    logic [NSYNC-1:0] rawIn;
    logic [NSYNC-1:0] metaReg;
    logic [NSYNC-1:0] syncReg;
    logic             prevGReg;
    logic             prevCollReg;
    logic             pressG;
    logic             hit;

`ifdef GAME_PAUSE_EN
    logic             prevPReg;
    logic             pressP;
    assign rawIn  = {pbP_in, collision, pbG_in, pbR_in, pbL_in};
    assign pressP = prevPReg & ~syncReg[4];
`else
    assign rawIn  = {collision, pbG_in, pbR_in, pbL_in};
`endif

    assign pressG = prevGReg & ~syncReg[2];
    assign hit    = syncReg[3] & ~prevCollReg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            metaReg     <= SYNC_INIT;
            syncReg     <= SYNC_INIT;
            prevGReg    <= 1'b1;
            prevCollReg <= 1'b0;
`ifdef GAME_PAUSE_EN
            prevPReg    <= 1'b1;
`endif
        end else begin
            metaReg     <= rawIn;
            syncReg     <= metaReg;
            prevGReg    <= syncReg[2];
            prevCollReg <= syncReg[3];
`ifdef GAME_PAUSE_EN
            prevPReg    <= syncReg[4];
`endif
        end
    end

    gameState_t stateReg, stateNext;
    logic [7:0] cntReg, cntNext;
    logic [3:0] scoreReg, scoreNext;
    logic       roundRstReg, roundRstNext;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stateReg    <= IDLE;
            cntReg      <= 8'd0;
            scoreReg    <= 4'd0;
            roundRstReg <= 1'b1;
        end else begin
            stateReg    <= stateNext;
            cntReg      <= cntNext;
            scoreReg    <= scoreNext;
            roundRstReg <= roundRstNext;
        end
    end

    always_comb begin
        stateNext    = stateReg;
        cntNext      = cntReg;
        scoreNext    = scoreReg;
        roundRstNext = 1'b1;
        case (stateReg)
            IDLE: begin
                if (pressG) begin
                    stateNext    = COUNTDOWN;
                    cntNext      = START_CNT;
                    scoreNext    = 4'd0;
                    roundRstNext = 1'b0;
                end
            end
            COUNTDOWN: begin
                // A count of 0 or 1 both expire on this tick (covers START_FRAMES = 0).
                if (frame_tick) begin
                    if (cntReg <= 8'd1) begin
                        stateNext = PLAY;
                        cntNext   = 8'd0;
                    end else begin
                        cntNext = cntReg - 8'd1;
                    end
                end
            end
            PLAY: begin
                if (hit && (scoreReg < SCORE_TOP)) begin
                    scoreNext = scoreReg + 4'd1;
                end
                if (endgame_lose) begin
                    stateNext = LOSE;
                    cntNext   = 8'd0;
                end else if (endgame_win) begin
                    stateNext = WIN;
                    cntNext   = 8'd0;
                end
`ifdef GAME_PAUSE_EN
                else if (pressP) begin
                    stateNext = PAUSE;
                end
`endif
            end
            WIN, LOSE: begin
                if (frame_tick && (cntReg < HOLD_CNT)) begin
                    cntNext = cntReg + 8'd1;
                end
                if (pressG && (cntReg == HOLD_CNT)) begin
                    stateNext = IDLE;
                    cntNext   = 8'd0;
                end
            end
`ifdef GAME_PAUSE_EN
            PAUSE: begin
                if (pressP) begin
                    stateNext = PLAY;
                end
            end
`endif
            default: begin
                stateNext = IDLE;
                cntNext   = 8'd0;
            end
        endcase
    end

    assign move_en     = (stateReg == PLAY);
    assign pbL_out     = move_en ? syncReg[0] : 1'b1;
    assign pbR_out     = move_en ? syncReg[1] : 1'b1;
    assign pbG_out     = move_en ? syncReg[2] : 1'b1;
    assign round_rst_n = roundRstReg;
    assign state       = stateReg;
    assign score       = scoreReg;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed bench for game_flow_ctrl: vector table for the start-up flow, hand sequences for
// scoring, endgame, hold timing, mid-round reset and (with GAME_PAUSE_EN) pause.
module tb_game_flow_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       frameTick = 1'b0;
    logic       pbL = 1'b1, pbR = 1'b1, pbG = 1'b1;
    logic       coll = 1'b0, win = 1'b0, lose = 1'b0;
`ifdef GAME_PAUSE_EN
    logic       pbP = 1'b1;
`endif
    logic       pbLOut, pbROut, pbGOut, roundRstN, moveEn;
    logic [2:0] state;
    logic [3:0] score;

    int vecCount  = 0;
    int missCount = 0;

    always #5 clk = ~clk;

    game_flow_ctrl #(.START_FRAMES(3), .HOLD_FRAMES(2), .SCORE_MAX(9)) dut (
        .clk          (clk),
        .reset        (reset),
        .frame_tick   (frameTick),
        .pbL_in       (pbL),
        .pbR_in       (pbR),
        .pbG_in       (pbG),
`ifdef GAME_PAUSE_EN
        .pbP_in       (pbP),
`endif
        .collision    (coll),
        .endgame_win  (win),
        .endgame_lose (lose),
        .pbL_out      (pbLOut),
        .pbR_out      (pbROut),
        .pbG_out      (pbGOut),
        .round_rst_n  (roundRstN),
        .move_en      (moveEn),
        .state        (state),
        .score        (score)
    );

    typedef struct {
        logic       pbL, pbR, pbG, coll, win, lose, tick;
        int         cyc;
        logic [11:0] exp;
    } vec_t;

    vec_t tbl[16];

    // Expected tuple: {state, score, pbL/R/G_out, move_en, round_rst_n}
    function automatic logic [11:0] ex(input logic [2:0] st, input logic [3:0] sc,
                                       input logic [2:0] pb, input logic mv, input logic rr);
        return {st, sc, pb, mv, rr};
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [11:0] exp);
        logic [11:0] got;
        got = {state, score, pbLOut, pbROut, pbGOut, moveEn, roundRstN};
        vecCount++;
        if (got !== exp) begin
            missCount++;
            $display("FAIL %s: got st=%0d sc=%0d pb=%b mv=%b rr=%b, expected st=%0d sc=%0d pb=%b mv=%b rr=%b",
                     name, got[11:9], got[8:5], got[4:2], got[1], got[0],
                     exp[11:9], exp[8:5], exp[4:2], exp[1], exp[0]);
        end else begin
            $display("ok   %s: st=%0d sc=%0d pb=%b mv=%b rr=%b",
                     name, got[11:9], got[8:5], got[4:2], got[1], got[0]);
        end
    endtask

    task automatic pulseColl();
        coll = 1'b1; cyc(4);
        coll = 1'b0; cyc(4);
    endtask

    task automatic pressG();
        pbG = 1'b0; cyc(3);
        pbG = 1'b1; cyc(3);
    endtask

    task automatic tick();
        frameTick = 1'b1; cyc(1);
        frameTick = 1'b0; cyc(1);
    endtask

`ifdef GAME_PAUSE_EN
    task automatic pressP();
        pbP = 1'b0; cyc(3);
        pbP = 1'b1; cyc(3);
    endtask
`endif

    initial begin
        //             L     R     G     coll  win   lose  tick  cyc  expected
        tbl[0]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2, ex(3'd0, 4'd0, 3'b111, 1'b0, 1'b1)};
        tbl[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2, ex(3'd0, 4'd0, 3'b111, 1'b0, 1'b1)};
        tbl[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2, ex(3'd0, 4'd0, 3'b111, 1'b0, 1'b1)};
        tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1, ex(3'd0, 4'd0, 3'b111, 1'b0, 1'b1)};
        tbl[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1, ex(3'd0, 4'd0, 3'b111, 1'b0, 1'b1)};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1, ex(3'd1, 4'd0, 3'b111, 1'b0, 1'b0)};
        tbl[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1, ex(3'd1, 4'd0, 3'b111, 1'b0, 1'b1)};
        tbl[7]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1, ex(3'd1, 4'd0, 3'b111, 1'b0, 1'b1)};
        tbl[8]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1, ex(3'd1, 4'd0, 3'b111, 1'b0, 1'b1)};
        tbl[9]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1, ex(3'd1, 4'd0, 3'b111, 1'b0, 1'b1)};
        tbl[10] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1, ex(3'd1, 4'd0, 3'b111, 1'b0, 1'b1)};
        tbl[11] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1, ex(3'd2, 4'd0, 3'b111, 1'b1, 1'b1)};
        tbl[12] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2, ex(3'd2, 4'd0, 3'b011, 1'b1, 1'b1)};
        tbl[13] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2, ex(3'd2, 4'd0, 3'b101, 1'b1, 1'b1)};
        tbl[14] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2, ex(3'd2, 4'd0, 3'b110, 1'b1, 1'b1)};
        tbl[15] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3, ex(3'd2, 4'd0, 3'b111, 1'b1, 1'b1)};

        // Reset state, then the start-up flow from the table
        cyc(2);
        check("reset_state", ex(3'd0, 4'd0, 3'b111, 1'b0, 1'b1));
        reset = 1'b1;
        cyc(1);
        for (int i = 0; i < 16; i++) begin
            pbL = tbl[i].pbL; pbR = tbl[i].pbR; pbG = tbl[i].pbG;
            coll = tbl[i].coll; win = tbl[i].win; lose = tbl[i].lose;
            frameTick = tbl[i].tick;
            cyc(tbl[i].cyc);
            check($sformatf("vec%0d", i), tbl[i].exp);
        end
        frameTick = 1'b0;

        // Score steps 1..9 then saturates
        for (int i = 0; i < 12; i++) begin
            pulseColl();
            check($sformatf("hit%0d", i + 1),
                  ex(3'd2, (i < 9) ? 4'(i + 1) : 4'd9, 3'b111, 1'b1, 1'b1));
        end

        // Win and lose together with buttons held: LOSE, buttons locked
        win = 1'b1; lose = 1'b1; pbL = 1'b0; pbR = 1'b0; pbG = 1'b0;
        cyc(1);
        check("both_end_1clk", ex(3'd4, 4'd9, 3'b111, 1'b0, 1'b1));
        cyc(2);
        check("lose_locked", ex(3'd4, 4'd9, 3'b111, 1'b0, 1'b1));
        win = 1'b0; lose = 1'b0; pbL = 1'b1; pbR = 1'b1; pbG = 1'b1;
        cyc(3);
        pulseColl();
        check("lose_score_frozen", ex(3'd4, 4'd9, 3'b111, 1'b0, 1'b1));

        // Hold time: early press ignored, press after saturation returns to IDLE
        tick();
        pressG();
        check("early_press", ex(3'd4, 4'd9, 3'b111, 1'b0, 1'b1));
        tick();
        tick();
        pressG();
        check("hold_press_idle", ex(3'd0, 4'd9, 3'b111, 1'b0, 1'b1));
        pressG();
        check("new_round", ex(3'd1, 4'd0, 3'b111, 1'b0, 1'b1));

        // Mid-round async reset
        tick(); tick(); tick();
        check("play_again", ex(3'd2, 4'd0, 3'b111, 1'b1, 1'b1));
        for (int i = 0; i < 5; i++) pulseColl();
        pbL = 1'b0; pbR = 1'b0; pbG = 1'b0;
        cyc(3);
        check("play_score5_pressed", ex(3'd2, 4'd5, 3'b000, 1'b1, 1'b1));
        reset = 1'b0;
        #1;
        check("async_reset", ex(3'd0, 4'd0, 3'b111, 1'b0, 1'b1));
        #9;
        reset = 1'b1;
        pbL = 1'b1; pbR = 1'b1; pbG = 1'b1;
        cyc(3);
        check("after_reset", ex(3'd0, 4'd0, 3'b111, 1'b0, 1'b1));

`ifdef GAME_PAUSE_EN
        pressG();
        tick(); tick(); tick();
        pulseColl();
        check("pause_pre", ex(3'd2, 4'd1, 3'b111, 1'b1, 1'b1));
        pressP();
        check("paused", ex(3'd5, 4'd1, 3'b111, 1'b0, 1'b1));
        pulseColl();
        lose = 1'b1; cyc(2); lose = 1'b0; cyc(1);
        check("pause_ignores", ex(3'd5, 4'd1, 3'b111, 1'b0, 1'b1));
        pressP();
        check("resumed", ex(3'd2, 4'd1, 3'b111, 1'b1, 1'b1));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
